branch_resolve_unit: RTL and testbench

- Sequential consumer of the ID-stage operand-equality decision.
- Accepts a decoded branch from ID and waits, stalling ID/IF, until both forwarded operands are valid.
- Evaluates the branch condition on the forwarded rs/rt values and issues a registered, single-cycle PC redirect with the target address.
- Sits between the ID-stage forwarding muxes and the PC/NPC logic; keeps taken/not-taken counters for the performance registers.

---
 rtl/branch_resolve_unit_pkg.sv | 25 ++
 rtl/branch_resolve_unit_br_cond_eval.sv | 32 +++
 rtl/branch_resolve_unit.sv | 98 +++++++++
 tb/tb_branch_resolve_unit.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_resolve_unit_pkg.sv
// Shared encodings for the ID-stage branch resolver.
package branch_resolve_unit_pkg;

   localparam logic [2:0] BR_NONE = 3'b000;
   localparam logic [2:0] BR_BEQ  = 3'b001;
   localparam logic [2:0] BR_BNE  = 3'b010;
   localparam logic [2:0] BR_BLEZ = 3'b011;
   localparam logic [2:0] BR_BGTZ = 3'b100;
   localparam logic [2:0] BR_BLTZ = 3'b101;
   localparam logic [2:0] BR_BGEZ = 3'b110;
   localparam logic [2:0] BR_RSVD = 3'b111;

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_WAIT = 1'b1;

   function automatic logic single_op(input logic [2:0] t);
      return (t == BR_BLEZ) || (t == BR_BGTZ) ||
             (t == BR_BLTZ) || (t == BR_BGEZ);
   endfunction

   function automatic logic valid_type(input logic [2:0] t);
      return (t != BR_NONE) && (t != BR_RSVD);
   endfunction

endpackage

// File: rtl/branch_resolve_unit_br_cond_eval.sv
// Combinational branch condition: equality and sign tests on rs/rt.
module br_cond_eval
   import branch_resolve_unit_pkg::*;
(
   input  logic [2:0]  br_type,
   input  logic [31:0] rs_val,
   input  logic [31:0] rt_val,
   output logic        taken
);

   logic eq;
   logic rs_zero;
   logic rs_neg;

   assign eq      = (rs_val == rt_val);
   assign rs_zero = (rs_val == 32'd0);
   assign rs_neg  = rs_val[31];

   always_comb begin
      taken = 1'b0;
      unique case (br_type)
         BR_BEQ:  taken = eq;
         BR_BNE:  taken = ~eq;
         BR_BLEZ: taken = rs_neg | rs_zero;
         BR_BGTZ: taken = ~rs_neg & ~rs_zero;
         BR_BLTZ: taken = rs_neg;
         BR_BGEZ: taken = ~rs_neg;
         default: taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolver: waits for forwarded operands, then issues a
// registered one-cycle PC redirect and updates taken/not-taken counts.
module branch_resolve_unit
   import branch_resolve_unit_pkg::*;
#(
   parameter int MAX_WAIT = 4,
   parameter int CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             br_valid,
   input  logic [2:0]       br_type,
   input  logic [31:0]      rs_val,
   input  logic [31:0]      rt_val,
   input  logic             rs_ready,
   input  logic             rt_ready,
   input  logic [31:0]      pc_id,
   input  logic [15:0]      imm16,
   output logic             stall,
   output logic             redirect,
   output logic [31:0]      target,
   output logic             timeout,
   output logic [CNT_W-1:0] taken_cnt,
   output logic [CNT_W-1:0] ntaken_cnt
);

   localparam logic [3:0]       MW  = 4'(MAX_WAIT);
   localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [0:0]  state;
   logic [0:0]  state_nxt;
   logic [3:0]  wcnt;
   logic [3:0]  wcnt_nxt;
   logic        act;
   logic        need;
   logic        resolve;
   logic        taken;
   logic        to_hit;
   logic [31:0] tgt;

   assign act     = br_valid & valid_type(br_type);
   assign need    = rs_ready & (rt_ready | single_op(br_type));
   assign resolve = act & need;
   // Gated by rst_n so reset clears the stall immediately.
   assign stall   = act & ~need & rst_n;
   assign tgt     = pc_id + 32'd4 + {{14{imm16[15]}}, imm16, 2'b00};

   br_cond_eval u_cond (
      .br_type (br_type),
      .rs_val  (rs_val),
      .rt_val  (rt_val),
      .taken   (taken)
   );

   always_comb begin
      state_nxt = S_IDLE;
      wcnt_nxt  = wcnt;
      if (act & ~need) begin
         state_nxt = S_WAIT;
         if (state == S_IDLE) begin
            wcnt_nxt = 4'd1;
         end else if (wcnt != MW) begin
            wcnt_nxt = wcnt + 4'd1;
         end
      end
   end

   assign to_hit = act & ~need & (wcnt_nxt == MW);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         wcnt       <= 4'd0;
         redirect   <= 1'b0;
         target     <= 32'd0;
         timeout    <= 1'b0;
         taken_cnt  <= '0;
         ntaken_cnt <= '0;
      end else begin
         state    <= state_nxt;
         wcnt     <= wcnt_nxt;
         redirect <= resolve & taken;
         if (to_hit) begin
            timeout <= 1'b1;
         end
         if (resolve & taken) begin
            target <= tgt;
         end
         if (resolve & taken & (taken_cnt != '1)) begin
            taken_cnt <= taken_cnt + ONE;
         end
         if (resolve & ~taken & (ntaken_cnt != '1)) begin
            ntaken_cnt <= ntaken_cnt + ONE;
         end
      end
   end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed table plus hand sequences for branch_resolve_unit.
module tb_branch_resolve_unit;
   import branch_resolve_unit_pkg::*;

   localparam int CW = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          br_valid;
   logic [2:0]    br_type;
   logic [31:0]   rs_val;
   logic [31:0]   rt_val;
   logic          rs_ready;
   logic          rt_ready;
   logic [31:0]   pc_id;
   logic [15:0]   imm16;
   logic          stall;
   logic          redirect;
   logic [31:0]   target;
   logic          timeout;
   logic [CW-1:0] taken_cnt;
   logic [CW-1:0] ntaken_cnt;

   int total = 0;
   int bad   = 0;

   int          exp_t;
   int          exp_n;
   logic [31:0] exp_tgt;

   branch_resolve_unit #(.MAX_WAIT(4), .CNT_W(CW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .br_valid   (br_valid),
      .br_type    (br_type),
      .rs_val     (rs_val),
      .rt_val     (rt_val),
      .rs_ready   (rs_ready),
      .rt_ready   (rt_ready),
      .pc_id      (pc_id),
      .imm16      (imm16),
      .stall      (stall),
      .redirect   (redirect),
      .target     (target),
      .timeout    (timeout),
      .taken_cnt  (taken_cnt),
      .ntaken_cnt (ntaken_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        v;
      logic [2:0]  t;
      logic [31:0] rs;
      logic [31:0] rt;
      logic        rsr;
      logic        rtr;
      logic [31:0] pc;
      logic [15:0] imm;
      logic        cnt;
      logic        tk;
      logic [31:0] tgt;
   } vec_t;

   vec_t vt[14];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic drv(input logic v, input logic [2:0] t,
                      input logic [31:0] rs, input logic [31:0] rt,
                      input logic rsr, input logic rtr,
                      input logic [31:0] pc, input logic [15:0] imm);
      br_valid = v;
      br_type  = t;
      rs_val   = rs;
      rt_val   = rt;
      rs_ready = rsr;
      rt_ready = rtr;
      pc_id    = pc;
      imm16    = imm;
   endtask

   task automatic chk_regs(input string tag);
      chk({tag, ".target"}, target, exp_tgt);
      chk({tag, ".taken_cnt"}, 32'(taken_cnt), 32'(exp_t));
      chk({tag, ".ntaken_cnt"}, 32'(ntaken_cnt), 32'(exp_n));
   endtask

   initial begin
      vt[0]  = '{1, BR_BEQ,  32'h1234, 32'h1234, 1, 1,
                 32'h3000, 16'h0004, 1, 1, 32'h3014};
      vt[1]  = '{1, BR_BNE,  32'd5, 32'd5, 1, 1,
                 32'h3100, 16'h0004, 1, 0, 32'h0};
      vt[2]  = '{1, BR_BLEZ, 32'h80000000, 32'd7, 1, 0,
                 32'h0100, 16'h0010, 1, 1, 32'h0144};
      vt[3]  = '{1, BR_BGEZ, 32'd0, 32'd9, 1, 0,
                 32'h0200, 16'hFFFE, 1, 1, 32'h01FC};
      vt[4]  = '{1, BR_BLTZ, 32'd0, 32'd0, 1, 0,
                 32'h0300, 16'h0008, 1, 0, 32'h0};
      vt[5]  = '{1, BR_BEQ,  32'd1, 32'd1, 1, 1,
                 32'hFFFFFFF8, 16'h0001, 1, 1, 32'h0};
      vt[6]  = '{1, BR_BNE,  32'd1, 32'd2, 1, 1,
                 32'h4000, 16'h8000, 1, 1, 32'hFFFE4004};
      vt[7]  = '{1, BR_BGTZ, 32'd0, 32'd3, 1, 0,
                 32'h0400, 16'h0004, 1, 0, 32'h0};
      vt[8]  = '{1, BR_BLEZ, 32'd1, 32'd0, 1, 0,
                 32'h0404, 16'h0004, 1, 0, 32'h0};
      vt[9]  = '{1, BR_BLTZ, 32'hFFFFFFFF, 32'd0, 1, 0,
                 32'h0500, 16'h0000, 1, 1, 32'h0504};
      vt[10] = '{1, BR_NONE, 32'd1, 32'd1, 0, 0,
                 32'h0600, 16'h0004, 0, 0, 32'h0};
      vt[11] = '{1, BR_RSVD, 32'd1, 32'd1, 0, 0,
                 32'h0700, 16'h0004, 0, 0, 32'h0};
      vt[12] = '{1, BR_BGEZ, 32'h7FFFFFFF, 32'd0, 1, 0,
                 32'h0010, 16'h0001, 1, 1, 32'h0018};
      vt[13] = '{0, BR_BEQ,  32'd1, 32'd1, 1, 1,
                 32'h0800, 16'h0004, 0, 0, 32'h0};

      rst_n = 1'b0;
      drv(0, BR_NONE, 0, 0, 0, 0, 0, 0);
      #1;
      chk("rst.stall", 32'(stall), 0);
      chk("rst.redirect", 32'(redirect), 0);
      chk("rst.target", target, 0);
      chk("rst.timeout", 32'(timeout), 0);
      chk("rst.taken_cnt", 32'(taken_cnt), 0);
      chk("rst.ntaken_cnt", 32'(ntaken_cnt), 0);
      exp_t   = 0;
      exp_n   = 0;
      exp_tgt = 32'h0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // back-to-back single-cycle resolves
      for (int i = 0; i < 14; i++) begin
         drv(vt[i].v, vt[i].t, vt[i].rs, vt[i].rt, vt[i].rsr,
             vt[i].rtr, vt[i].pc, vt[i].imm);
         @(negedge clk);
         chk($sformatf("vec%0d.stall", i), 32'(stall), 0);
         @(posedge clk);
         #1;
         if (vt[i].cnt) begin
            if (vt[i].tk) begin
               exp_t++;
               exp_tgt = vt[i].tgt;
            end else begin
               exp_n++;
            end
         end
         chk($sformatf("vec%0d.redirect", i), 32'(redirect),
             32'(vt[i].cnt & vt[i].tk));
         chk_regs($sformatf("vec%0d", i));
      end

      // bgtz waits two cycles for rs
      drv(1, BR_BGTZ, 32'd1, 32'd0, 0, 0, 32'h0800, 16'hFFFF);
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         chk($sformatf("wait%0d.stall", c), 32'(stall), 1);
         chk($sformatf("wait%0d.redirect", c), 32'(redirect), 0);
         @(posedge clk);
         #1;
      end
      rs_ready = 1'b1;
      @(negedge clk);
      chk("wait.rdy.stall", 32'(stall), 0);
      @(posedge clk);
      #1;
      exp_t++;
      exp_tgt = 32'h0800;
      chk("wait.redirect", 32'(redirect), 1);
      chk_regs("wait");
      drv(0, BR_NONE, 0, 0, 0, 0, 32'h0900, 0);
      @(posedge clk);
      #1;
      chk("wait.pulse_end", 32'(redirect), 0);
      chk("wait.hold", target, exp_tgt);

      // br_valid dropped while waiting
      drv(1, BR_BNE, 32'd1, 32'd2, 1, 0, 32'h0A00, 16'h0004);
      @(negedge clk);
      chk("flush.stall", 32'(stall), 1);
      @(posedge clk);
      #1;
      br_valid = 1'b0;
      @(negedge clk);
      chk("flush.stall_off", 32'(stall), 0);
      @(posedge clk);
      #1;
      chk("flush.redirect", 32'(redirect), 0);
      chk_regs("flush");
      chk("flush.timeout", 32'(timeout), 0);

      // timeout on 4th WAIT cycle, sticky past resolution
      drv(1, BR_BGTZ, 32'd5, 32'd0, 0, 0, 32'h0000, 16'h0000);
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         chk($sformatf("to%0d.stall", c), 32'(stall), 1);
         chk($sformatf("to%0d.timeout", c), 32'(timeout),
             32'(c >= 4));
         @(posedge clk);
         #1;
      end
      rs_ready = 1'b1;
      @(posedge clk);
      #1;
      exp_t++;
      exp_tgt = 32'h4;
      chk("to.redirect", 32'(redirect), 1);
      chk("to.sticky", 32'(timeout), 1);
      chk_regs("to");

      // reset while waiting
      drv(1, BR_BEQ, 32'd1, 32'd1, 1, 0, 32'h0B00, 16'h0004);
      @(negedge clk);
      chk("rw.stall", 32'(stall), 1);
      #1;
      rst_n = 1'b0;
      #1;
      exp_t   = 0;
      exp_n   = 0;
      exp_tgt = 32'h0;
      chk("rw.stall0", 32'(stall), 0);
      chk("rw.redirect", 32'(redirect), 0);
      chk("rw.timeout", 32'(timeout), 0);
      chk_regs("rw");
      br_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("rw.after_redirect", 32'(redirect), 0);

      // counter saturation: 2^CW+3 taken branches
      drv(1, BR_BEQ, 32'd3, 32'd3, 1, 1, 32'h1000, 16'h0002);
      for (int k = 0; k < (1 << CW) + 3; k++) begin
         @(posedge clk);
      end
      #1;
      br_valid = 1'b0;
      chk("sat.taken_cnt", 32'(taken_cnt), (1 << CW) - 1);
      chk("sat.ntaken_cnt", 32'(ntaken_cnt), 0);
      chk("sat.target", target, 32'h100C);
      @(posedge clk);
      #1;
      chk("sat.redirect_end", 32'(redirect), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
